// File: rtl/amm_trans_block.sv
// Avalon-MM master issue stage: turns one operation packet into a burst write or a burst
// read request and tracks outstanding read beats.
module amm_trans_block #(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 64,
   parameter int unsigned AMM_BURST_W = 8,
   parameter string       ADDR_TYPE   = "BYTE",
   parameter int unsigned RD_CNT_W    = 12,
   localparam int unsigned BYTES      = DATA_W / 8,
   localparam int unsigned ADDR_B_W   = $clog2(BYTES)
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   op_valid_i,
   input  logic                   op_type_i,
   input  logic [ADDR_W-1:0]      op_word_addr_i,
   input  logic [ADDR_B_W-1:0]    op_start_offset_i,
   input  logic [ADDR_B_W-1:0]    op_end_offset_i,
   input  logic [AMM_BURST_W-1:0] op_burstcount_i,
   input  logic [7:0]             data_seed_i,
   output logic                   cmd_accept_ready_o,
   output logic [ADDR_W-1:0]      amm_address_o,
   output logic [AMM_BURST_W-1:0] amm_burstcount_o,
   output logic                   amm_write_o,
   output logic                   amm_read_o,
   output logic [DATA_W-1:0]      amm_writedata_o,
   output logic [BYTES-1:0]       amm_byteenable_o,
   input  logic                   amm_waitrequest_i,
   input  logic                   amm_readdatavalid_i,
   output logic                   trans_busy_o,
   output logic                   unexp_rdv_o
);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] WR_BURST = 2'd1;
   localparam logic [1:0] RD_REQ   = 2'd2;

   // Headroom so that a maximum-length read can always be absorbed by the counter.
   localparam logic [RD_CNT_W-1:0] RD_LIMIT =
      RD_CNT_W'((2 ** RD_CNT_W) - 1 - (2 ** (AMM_BURST_W - 1)));
   localparam bit WORD_MODE = (ADDR_TYPE == "WORD");

   logic [1:0]             state_q, state_d;
   logic [AMM_BURST_W-1:0] beat_q, beat_d, beat_nxt;
   logic [ADDR_W-1:0]      addr_q, addr_d;
   logic [AMM_BURST_W-1:0] bc_q, bc_d;
   logic [ADDR_B_W-1:0]    so_q, so_d, eo_q, eo_d;
   logic                   write_q, write_d, read_q, read_d;
   logic [DATA_W-1:0]      wdata_q, wdata_d;
   logic [BYTES-1:0]       be_q, be_d;
   logic [RD_CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
   logic                   unexp_q, unexp_d;
   logic                   ready_q, ready_d, busy_q, busy_d;
   logic                   rd_add;

   function automatic logic [DATA_W-1:0] beat_data(input logic [7:0] seed,
                                                   input logic [AMM_BURST_W-1:0] n);
      logic [DATA_W-1:0] d;
      logic [7:0]        base;
      base = seed + 8'(32'(n) * BYTES);
      for (int k = 0; k < int'(BYTES); k++) begin
         d[8*k +: 8] = base + 8'(k);
      end
      return d;
   endfunction

   function automatic logic [BYTES-1:0] beat_be(input logic [AMM_BURST_W-1:0] n,
                                                input logic [AMM_BURST_W-1:0] bc,
                                                input logic [ADDR_B_W-1:0]    so,
                                                input logic [ADDR_B_W-1:0]    eo);
      logic [BYTES-1:0] ones;
      logic [BYTES-1:0] m;
      ones = '1;
      m    = ones;
      if (!WORD_MODE) begin
         if (n == '0) m = m & (ones << so);
         if (n == bc - AMM_BURST_W'(1)) m = m & (ones >> (ADDR_B_W'(BYTES - 1) - eo));
      end
      return m;
   endfunction

   always_comb begin
      state_d  = state_q;
      beat_d   = beat_q;
      addr_d   = addr_q;
      bc_d     = bc_q;
      so_d     = so_q;
      eo_d     = eo_q;
      write_d  = write_q;
      read_d   = read_q;
      wdata_d  = wdata_q;
      be_d     = be_q;
      rd_add   = 1'b0;
      beat_nxt = beat_q + AMM_BURST_W'(1);

      case (state_q)
         IDLE: begin
            if (op_valid_i && ready_q) begin
               addr_d  = op_word_addr_i;
               bc_d    = op_burstcount_i;
               so_d    = op_start_offset_i;
               eo_d    = op_end_offset_i;
               beat_d  = '0;
               wdata_d = beat_data(data_seed_i, '0);
               be_d    = beat_be('0, op_burstcount_i, op_start_offset_i, op_end_offset_i);
               if (op_type_i) begin
                  state_d = RD_REQ;
                  read_d  = 1'b1;
               end else begin
                  state_d = WR_BURST;
                  write_d = 1'b1;
               end
            end
         end
         WR_BURST: begin
            if (!amm_waitrequest_i) begin
               if (beat_q == bc_q - AMM_BURST_W'(1)) begin
                  state_d = IDLE;
                  write_d = 1'b0;
               end else begin
                  beat_d  = beat_nxt;
                  wdata_d = beat_data(data_seed_i, beat_nxt);
                  be_d    = beat_be(beat_nxt, bc_q, so_q, eo_q);
               end
            end
         end
         RD_REQ: begin
            if (!amm_waitrequest_i) begin
               state_d = IDLE;
               read_d  = 1'b0;
               rd_add  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            write_d = 1'b0;
            read_d  = 1'b0;
         end
      endcase

      // A beat returning with nothing outstanding is flagged rather than wrapping the counter.
      rd_cnt_d = rd_cnt_q;
      unexp_d  = unexp_q;
      if (amm_readdatavalid_i) begin
         if (rd_cnt_q == '0) unexp_d = 1'b1;
         else rd_cnt_d = rd_cnt_q - RD_CNT_W'(1);
      end
      if (rd_add) rd_cnt_d = rd_cnt_d + RD_CNT_W'(bc_q);

      ready_d = (state_d == IDLE) && (rd_cnt_d <= RD_LIMIT);
      busy_d  = (state_d != IDLE) || (rd_cnt_d != '0);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         beat_q   <= '0;
         addr_q   <= '0;
         bc_q     <= '0;
         so_q     <= '0;
         eo_q     <= '0;
         write_q  <= 1'b0;
         read_q   <= 1'b0;
         wdata_q  <= '0;
         be_q     <= '0;
         rd_cnt_q <= '0;
         unexp_q  <= 1'b0;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         beat_q   <= beat_d;
         addr_q   <= addr_d;
         bc_q     <= bc_d;
         so_q     <= so_d;
         eo_q     <= eo_d;
         write_q  <= write_d;
         read_q   <= read_d;
         wdata_q  <= wdata_d;
         be_q     <= be_d;
         rd_cnt_q <= rd_cnt_d;
         unexp_q  <= unexp_d;
         ready_q  <= ready_d;
         busy_q   <= busy_d;
      end
   end

   assign cmd_accept_ready_o = ready_q;
   assign amm_address_o      = addr_q;
   assign amm_burstcount_o   = bc_q;
   assign amm_write_o        = write_q;
   assign amm_read_o         = read_q;
   assign amm_writedata_o    = wdata_q;
   assign amm_byteenable_o   = be_q;
   assign trans_busy_o       = busy_q;
   assign unexp_rdv_o        = unexp_q;

endmodule

// File: tb/tb_amm_trans_block.sv
// Bench for amm_trans_block: BYTE and WORD instances share stimulus and are checked every
// cycle against a queue-based model of expected bus beats and outstanding read count.
module tb_amm_trans_block;

   localparam int LIMIT = 15 - 8;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        op_valid_i, op_type_i;
   logic [31:0] op_word_addr_i;
   logic [2:0]  op_start_offset_i, op_end_offset_i;
   logic [3:0]  op_burstcount_i;
   logic [7:0]  data_seed_i;
   logic        amm_waitrequest_i, amm_readdatavalid_i;

   logic        ready_b, write_b, read_b, busy_b, unexp_b;
   logic [31:0] addr_b;
   logic [3:0]  bc_b;
   logic [63:0] wdata_b;
   logic [7:0]  be_b;
   logic        ready_w, write_w, read_w, busy_w, unexp_w;
   logic [31:0] addr_w;
   logic [3:0]  bc_w;
   logic [63:0] wdata_w;
   logic [7:0]  be_w;

   amm_trans_block #(
      .ADDR_W(32), .DATA_W(64), .AMM_BURST_W(4), .ADDR_TYPE("BYTE"), .RD_CNT_W(4)
   ) dut_b (
      .clk_i(clk_i), .rst_i(rst_i), .op_valid_i(op_valid_i), .op_type_i(op_type_i),
      .op_word_addr_i(op_word_addr_i), .op_start_offset_i(op_start_offset_i),
      .op_end_offset_i(op_end_offset_i), .op_burstcount_i(op_burstcount_i),
      .data_seed_i(data_seed_i), .cmd_accept_ready_o(ready_b), .amm_address_o(addr_b),
      .amm_burstcount_o(bc_b), .amm_write_o(write_b), .amm_read_o(read_b),
      .amm_writedata_o(wdata_b), .amm_byteenable_o(be_b),
      .amm_waitrequest_i(amm_waitrequest_i), .amm_readdatavalid_i(amm_readdatavalid_i),
      .trans_busy_o(busy_b), .unexp_rdv_o(unexp_b)
   );

   amm_trans_block #(
      .ADDR_W(32), .DATA_W(64), .AMM_BURST_W(4), .ADDR_TYPE("WORD"), .RD_CNT_W(4)
   ) dut_w (
      .clk_i(clk_i), .rst_i(rst_i), .op_valid_i(op_valid_i), .op_type_i(op_type_i),
      .op_word_addr_i(op_word_addr_i), .op_start_offset_i(op_start_offset_i),
      .op_end_offset_i(op_end_offset_i), .op_burstcount_i(op_burstcount_i),
      .data_seed_i(data_seed_i), .cmd_accept_ready_o(ready_w), .amm_address_o(addr_w),
      .amm_burstcount_o(bc_w), .amm_write_o(write_w), .amm_read_o(read_w),
      .amm_writedata_o(wdata_w), .amm_byteenable_o(be_w),
      .amm_waitrequest_i(amm_waitrequest_i), .amm_readdatavalid_i(amm_readdatavalid_i),
      .trans_busy_o(busy_w), .unexp_rdv_o(unexp_w)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  bc;
      logic [63:0] data;
      logic [7:0]  be;
   } beat_t;

   beat_t       wq[$];
   logic        rd_pend;
   logic [31:0] rd_addr;
   logic [3:0]  rd_bc;
   logic [7:0]  rd_be;
   int          outst;
   logic        unexp_m;
   logic        acc_m;
   int          checks = 0;
   int          errors = 0;

   function automatic logic [63:0] mkdata(input logic [7:0] seed, input int n);
      logic [63:0] d;
      for (int k = 0; k < 8; k++) d[8*k +: 8] = 8'(int'(seed) + n * 8 + k);
      return d;
   endfunction

   function automatic logic [7:0] mkbe(input int n, input int bc, input int so, input int eo);
      logic [7:0] m;
      m = 8'hFF;
      for (int k = 0; k < 8; k++) begin
         if (n == 0 && k < so) m[k] = 1'b0;
         if (n == bc - 1 && k > eo) m[k] = 1'b0;
      end
      return m;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at the negedge with inputs already driven: checks outputs, then advances the model.
   task automatic cycle();
      logic idle, exp_ready;
      beat_t b;
      idle      = (wq.size() == 0) && !rd_pend;
      exp_ready = idle && (outst <= LIMIT);
      chk("ready_b", 64'(ready_b), 64'(exp_ready));
      chk("ready_w", 64'(ready_w), 64'(exp_ready));
      chk("write_b", 64'(write_b), 64'(wq.size() != 0));
      chk("write_w", 64'(write_w), 64'(wq.size() != 0));
      chk("read_b", 64'(read_b), 64'(rd_pend));
      chk("read_w", 64'(read_w), 64'(rd_pend));
      chk("busy_b", 64'(busy_b), 64'(!idle || outst != 0));
      chk("busy_w", 64'(busy_w), 64'(!idle || outst != 0));
      chk("unexp_b", 64'(unexp_b), 64'(unexp_m));
      chk("unexp_w", 64'(unexp_w), 64'(unexp_m));
      if (wq.size() != 0) begin
         b = wq[0];
         chk("wr_addr", 64'(addr_b), 64'(b.addr));
         chk("wr_bc", 64'(bc_w), 64'(b.bc));
         chk("wdata_b", wdata_b, b.data);
         chk("wdata_w", wdata_w, b.data);
         chk("wr_be_b", 64'(be_b), 64'(b.be));
         chk("wr_be_w", 64'(be_w), 64'hFF);
      end
      if (rd_pend) begin
         chk("rd_addr", 64'(addr_w), 64'(rd_addr));
         chk("rd_bc", 64'(bc_b), 64'(rd_bc));
         chk("rd_be_b", 64'(be_b), 64'(rd_be));
         chk("rd_be_w", 64'(be_w), 64'hFF);
      end
      if (wq.size() != 0 && !amm_waitrequest_i) void'(wq.pop_front());
      if (amm_readdatavalid_i) begin
         if (outst == 0) unexp_m = 1'b1;
         else outst--;
      end
      if (rd_pend && !amm_waitrequest_i) begin
         outst  += int'(rd_bc);
         rd_pend = 1'b0;
      end
      acc_m = op_valid_i && exp_ready;
      if (acc_m) begin
         if (op_type_i) begin
            rd_pend = 1'b1;
            rd_addr = op_word_addr_i;
            rd_bc   = op_burstcount_i;
            rd_be   = mkbe(0, int'(op_burstcount_i), int'(op_start_offset_i),
                           int'(op_end_offset_i));
         end else begin
            for (int n = 0; n < int'(op_burstcount_i); n++) begin
               b.addr = op_word_addr_i;
               b.bc   = op_burstcount_i;
               b.data = mkdata(data_seed_i, n);
               b.be   = mkbe(n, int'(op_burstcount_i), int'(op_start_offset_i),
                             int'(op_end_offset_i));
               wq.push_back(b);
            end
         end
      end
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic issue(input logic t, input logic [31:0] a, input int so, input int eo,
                        input int bc);
      op_type_i         = t;
      op_word_addr_i    = a;
      op_start_offset_i = 3'(so);
      op_end_offset_i   = 3'(eo);
      op_burstcount_i   = 4'(bc);
      op_valid_i        = 1'b1;
      acc_m             = 1'b0;
      for (int i = 0; i < 50 && !acc_m; i++) cycle();
      op_valid_i = 1'b0;
      chk("issue_accepted", 64'(acc_m), 64'd1);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic model_reset();
      wq.delete();
      rd_pend = 1'b0;
      outst   = 0;
      unexp_m = 1'b0;
   endtask

   initial begin
      rst_i = 1'b1;
      op_valid_i = 1'b0; op_type_i = 1'b0; op_word_addr_i = '0;
      op_start_offset_i = '0; op_end_offset_i = '0; op_burstcount_i = 4'd1;
      data_seed_i = 8'h10; amm_waitrequest_i = 1'b0; amm_readdatavalid_i = 1'b0;
      model_reset();
      #3;
      chk("rst_ready", 64'(ready_b), 64'd1);
      chk("rst_write", 64'(write_b), 64'd0);
      chk("rst_read", 64'(read_w), 64'd0);
      chk("rst_addr", 64'(addr_b), 64'd0);
      chk("rst_bc", 64'(bc_b), 64'd0);
      chk("rst_wdata", wdata_b, 64'd0);
      chk("rst_be", 64'(be_w), 64'd0);
      chk("rst_busy", 64'(busy_b), 64'd0);
      chk("rst_unexp", 64'(unexp_b), 64'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      @(negedge clk_i);

      // Full-width write burst, then partial-byte bursts.
      issue(1'b0, 32'h100, 0, 7, 4);
      idle_cycles(6);
      issue(1'b0, 32'h200, 3, 5, 1);
      idle_cycles(3);
      issue(1'b0, 32'h208, 3, 5, 3);
      idle_cycles(5);

      // Waitrequest stalls beat 1 for two cycles.
      issue(1'b0, 32'h300, 0, 7, 4);
      cycle();
      amm_waitrequest_i = 1'b1;
      idle_cycles(2);
      amm_waitrequest_i = 1'b0;
      idle_cycles(5);

      // Reads: counter saturation holds off the second request until a beat returns.
      issue(1'b1, 32'h400, 2, 6, 8);
      idle_cycles(3);
      amm_readdatavalid_i = 1'b1;
      issue(1'b1, 32'h440, 1, 4, 8);
      for (int i = 0; i < 40 && outst > 0; i++) cycle();
      amm_readdatavalid_i = 1'b0;
      chk("drain_done", 64'(outst), 64'd0);
      idle_cycles(3);

      // Readdatavalid with nothing outstanding.
      amm_readdatavalid_i = 1'b1;
      cycle();
      amm_readdatavalid_i = 1'b0;
      idle_cycles(2);

      // Asynchronous reset mid write burst.
      issue(1'b0, 32'h500, 0, 7, 8);
      idle_cycles(2);
      #2 rst_i = 1'b1;
      #1;
      chk("arst_write", 64'(write_b), 64'd0);
      chk("arst_ready", 64'(ready_w), 64'd1);
      chk("arst_busy", 64'(busy_b), 64'd0);
      chk("arst_unexp", 64'(unexp_w), 64'd0);
      model_reset();
      @(negedge clk_i);
      rst_i = 1'b0;
      issue(1'b0, 32'h600, 2, 1, 2);
      idle_cycles(4);

      // Randomized traffic.
      data_seed_i = 8'($urandom);
      for (int i = 0; i < 400; i++) begin
         op_valid_i          = ($urandom_range(0, 2) == 0);
         op_type_i           = 1'($urandom);
         op_word_addr_i      = $urandom & 32'hFFFF_FFF8;
         op_start_offset_i   = 3'($urandom);
         op_end_offset_i     = 3'($urandom);
         op_burstcount_i     = 4'($urandom_range(1, 8));
         amm_waitrequest_i   = ($urandom_range(0, 3) == 0);
         amm_readdatavalid_i = (outst > 0) && ($urandom_range(0, 1) == 0);
         cycle();
      end
      op_valid_i = 1'b0;
      amm_waitrequest_i = 1'b0;
      for (int i = 0; i < 60 && (outst > 0 || wq.size() != 0 || rd_pend); i++) begin
         amm_readdatavalid_i = (outst > 0);
         cycle();
      end
      amm_readdatavalid_i = 1'b0;
      idle_cycles(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
